// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-style datapath blocks.
// The register-file blocks take their default parameter values from here.
package mips_pkg;

    localparam int MIPS_NUM_REGS = 32;
    localparam int MIPS_DATA_W   = 32;
    localparam int MIPS_AW       = $clog2(MIPS_NUM_REGS);

    typedef logic [MIPS_DATA_W-1:0] word_t;
    typedef logic [MIPS_AW-1:0]     reg_idx_t;

    // Architectural zero register: reads as zero, never written, never pending.
    localparam reg_idx_t REG_ZERO = '0;

    // True when a write-back to idx actually changes architectural state.
    function automatic logic is_live_write(input logic we, input reg_idx_t idx);
        return we && (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// A bit is set when a producer issues, and cleared when that register is written back.
// flush squashes every in-flight producer at once.
// Priority at each edge is flush > issue (set) > write-back (clear).
// Setting wins over clearing because the issuing producer is younger than the
// one writing back.
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int NUM_REGS = MIPS_NUM_REGS,
    parameter int AW       = MIPS_AW,
    parameter bit BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          reg_write_w,
    input  logic [AW-1:0] write_reg_w,
    input  logic          issue_valid_d,
    input  logic [AW-1:0] issue_reg_d,
    input  logic          flush,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    output logic          pending_rs_d,
    output logic          pending_rt_d
);

    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_pend_nxt;
    logic                w_byp_rs;
    logic                w_byp_rt;

    // Decode the issue and write-back indices into set and clear masks.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_set = '0;
        w_clr = '0;
        if (issue_valid_d && (issue_reg_d != REG_ZERO)) begin
            w_set[issue_reg_d] = 1'b1;
        end
        if (reg_write_w) begin
            w_clr[write_reg_w] = 1'b1;
        end
    end

    // Next pending vector: flush clears all, otherwise the set mask overrides the clear mask.
    always_comb begin
        if (flush) begin
            w_pend_nxt = '0;
        end else begin
            w_pend_nxt = (r_pend & ~w_clr) | w_set;
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Pending-bit state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments, so every flop
            // samples values from before the edge, whatever the statement order.
            r_pend <= w_pend_nxt;
        end
    end

    // A bypassed write-back resolves the hazard in the cycle in which it happens.
    always_comb begin
        w_byp_rs     = BYPASS && reg_write_w && (write_reg_w == rs_d);
        w_byp_rt     = BYPASS && reg_write_w && (write_reg_w == rt_d);
        pending_rs_d = r_pend[rs_d] && !w_byp_rs;
        pending_rt_d = r_pend[rt_d] && !w_byp_rt;
    end

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file, written by the write-back stage.
// It has two combinational read ports for Decode, with an optional bypass that
// returns a write in the same cycle.
// The embedded pending-write scoreboard tells Decode when a source register
// still has a producer that has not written back.
module reg_file_wb
    import mips_pkg::*;
#(
    parameter int NUM_REGS = MIPS_NUM_REGS,
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int AW       = MIPS_AW,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    // write-back port
    input  logic              reg_write_w,
    input  logic [AW-1:0]     write_reg_w,
    input  logic [DATA_W-1:0] result_w,
    // decode read ports
    input  logic [AW-1:0]     rs_d,
    input  logic [AW-1:0]     rt_d,
    output logic [DATA_W-1:0] rd1_d,
    output logic [DATA_W-1:0] rd2_d,
    // scoreboard
    input  logic              issue_valid_d,
    input  logic [AW-1:0]     issue_reg_d,
    input  logic              flush,
    output logic              pending_rs_d,
    output logic              pending_rt_d
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_we_live;

    assign w_we_live = is_live_write(reg_write_w, write_reg_w);

    // Register storage: a flop array, written on live write-backs only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is cleared on reset, so it must be built from
            // resettable flops. A RAM macro cannot clear every entry at once.
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_live) begin
            r_regs[write_reg_w] <= result_w;
        end
    end

    // Read port 1: zero register, then bypass, then stored value.
    // The port is forced to zero while reset is held, so that the bypass path
    // cannot leak write-back data during reset.
    always_comb begin
        rd1_d = '0;
        if (rst_n && (rs_d != REG_ZERO)) begin
            if (BYPASS && reg_write_w && (write_reg_w == rs_d)) begin
                rd1_d = result_w;
            end else begin
                rd1_d = r_regs[rs_d];
            end
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rd2_d = '0;
        if (rst_n && (rt_d != REG_ZERO)) begin
            if (BYPASS && reg_write_w && (write_reg_w == rt_d)) begin
                rd2_d = result_w;
            end else begin
                rd2_d = r_regs[rt_d];
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .reg_write_w   (reg_write_w),
        .write_reg_w   (write_reg_w),
        .issue_valid_d (issue_valid_d),
        .issue_reg_d   (issue_reg_d),
        .flush         (flush),
        .rs_d          (rs_d),
        .rt_d          (rt_d),
        .pending_rs_d  (pending_rs_d),
        .pending_rt_d  (pending_rt_d)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb.
// Two instances share every input: one built with BYPASS=1 and one with BYPASS=0.
// A reference model of the register file and pending set is kept as plain arrays.
module tb_reg_file_wb;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] wr;
    logic [DW-1:0] res;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          iv;
    logic [AW-1:0] ir;
    logic          fl;

    logic [DW-1:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic          b_prs, b_prt, n_prs, n_prt;

    always #5 clk = ~clk;

    reg_file_wb #(.NUM_REGS(NR), .DATA_W(DW), .AW(AW), .BYPASS(1'b1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n),
        .reg_write_w(we), .write_reg_w(wr), .result_w(res),
        .rs_d(rs), .rt_d(rt), .rd1_d(b_rd1), .rd2_d(b_rd2),
        .issue_valid_d(iv), .issue_reg_d(ir), .flush(fl),
        .pending_rs_d(b_prs), .pending_rt_d(b_prt)
    );

    reg_file_wb #(.NUM_REGS(NR), .DATA_W(DW), .AW(AW), .BYPASS(1'b0)) u_dut_nob (
        .clk(clk), .rst_n(rst_n),
        .reg_write_w(we), .write_reg_w(wr), .result_w(res),
        .rs_d(rs), .rt_d(rt), .rd1_d(n_rd1), .rd2_d(n_rd2),
        .issue_valid_d(iv), .issue_reg_d(ir), .flush(fl),
        .pending_rs_d(n_prs), .pending_rt_d(n_prt)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_regs [NR];
    bit            m_pend [NR];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] idx, input bit byp);
        if (!rst_n || idx == 0) return '0;
        if (byp && we && wr == idx) return res;
        return m_regs[idx];
    endfunction

    function automatic logic exp_pend(input logic [AW-1:0] idx, input bit byp);
        if (!rst_n) return 1'b0;
        return m_pend[idx] && !(byp && we && wr == idx);
    endfunction

    // The state change at a clock edge, written as the stated rules in order.
    // A later statement overrides an earlier one: write-back clears, then a
    // younger issue sets, then flush clears everything.
    task automatic model_edge();
        if (!rst_n) return;
        if (we && wr != 0) m_regs[wr] = res;
        if (we) m_pend[wr] = 1'b0;
        if (iv && ir != 0) m_pend[ir] = 1'b1;
        if (fl) for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".byp.rd1"}, b_rd1, exp_rd(rs, 1'b1));
        check({tag, ".byp.rd2"}, b_rd2, exp_rd(rt, 1'b1));
        check({tag, ".byp.prs"}, {31'b0, b_prs}, {31'b0, exp_pend(rs, 1'b1)});
        check({tag, ".byp.prt"}, {31'b0, b_prt}, {31'b0, exp_pend(rt, 1'b1)});
        check({tag, ".nob.rd1"}, n_rd1, exp_rd(rs, 1'b0));
        check({tag, ".nob.rd2"}, n_rd2, exp_rd(rt, 1'b0));
        check({tag, ".nob.prs"}, {31'b0, n_prs}, {31'b0, exp_pend(rs, 1'b0)});
        check({tag, ".nob.prt"}, {31'b0, n_prt}, {31'b0, exp_pend(rt, 1'b0)});
    endtask

    // Advance one clock: update the model at the edge, then step clear of the edge.
    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic w_e, input logic [AW-1:0] w_r, input logic [DW-1:0] w_d,
                         input logic [AW-1:0] r_s, input logic [AW-1:0] r_t,
                         input logic i_v, input logic [AW-1:0] i_r, input logic f);
        we = w_e; wr = w_r; res = w_d; rs = r_s; rt = r_t; iv = i_v; ir = i_r; fl = f;
    endtask

    function automatic logic [AW-1:0] rand_idx();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NR - 1));
    endfunction

    // ---------------- directed table (BYPASS=1 expectations) ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] wr;
        logic [DW-1:0] res;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          iv;
        logic [AW-1:0] ir;
        logic          fl;
        logic [DW-1:0] e_rd1;
        logic [DW-1:0] e_rd2;
        logic          e_prs;
        logic          e_prt;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic w_e, input int w_r, input logic [DW-1:0] w_d,
                                input int r_s, input int r_t, input logic i_v, input int i_r,
                                input logic f, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                                input logic p1, input logic p2);
        vec_t v;
        v.we = w_e; v.wr = AW'(w_r); v.res = w_d; v.rs = AW'(r_s); v.rt = AW'(r_t);
        v.iv = i_v; v.ir = AW'(i_r); v.fl = f;
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_prs = p1; v.e_prt = p2;
        return v;
    endfunction

    initial begin
        //            we wr res            rs rt iv ir fl  rd1            rd2            prs prt
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0); // write r5, bypassed
        vecs[1]  = mk(0, 0, 32'h0,        5, 5, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0); // read back r5
        vecs[2]  = mk(1, 0, 32'h1234,     0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0); // write r0 dropped
        vecs[3]  = mk(0, 0, 32'h0,        0, 5, 0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0);
        vecs[4]  = mk(0, 0, 32'h0,        9, 9, 1, 9, 0, 32'h0,        32'h0,        0, 0); // issue r9
        vecs[5]  = mk(0, 0, 32'h0,        9, 5, 0, 0, 0, 32'h0,        32'hDEADBEEF, 1, 0); // r9 pending
        vecs[6]  = mk(0, 0, 32'h0,        9, 5, 0, 0, 0, 32'h0,        32'hDEADBEEF, 1, 0);
        vecs[7]  = mk(1, 9, 32'h99,       9, 9, 0, 0, 0, 32'h99,       32'h99,       0, 0); // WB r9, bypass
        vecs[8]  = mk(0, 0, 32'h0,        9, 9, 0, 0, 0, 32'h99,       32'h99,       0, 0);
        vecs[9]  = mk(1, 4, 32'h44,       4, 4, 1, 4, 0, 32'h44,       32'h44,       0, 0); // collision r4
        vecs[10] = mk(0, 0, 32'h0,        4, 4, 0, 0, 0, 32'h44,       32'h44,       1, 1); // set won
        vecs[11] = mk(0, 0, 32'h0,        4, 6, 1, 6, 1, 32'h44,       32'h0,        1, 0); // flush + issue r6
        vecs[12] = mk(0, 0, 32'h0,        4, 6, 0, 0, 0, 32'h44,       32'h0,        0, 0); // all cleared
        vecs[13] = mk(0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0); // issue r0 ignored
        vecs[14] = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0);
        vecs[15] = mk(1, 3, 32'h33,       4, 3, 0, 0, 0, 32'h44,       32'h33,       0, 0); // WB to non-pending
    end

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        rst_n = 1'b0;
        // Inputs busy during reset: outputs must still read as zero.
        drive(1'b1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd31, 1'b1, 5'd3, 1'b0);
        #1;
        check("rst.byp.rd1", b_rd1, 32'h0);
        check("rst.byp.rd2", b_rd2, 32'h0);
        check("rst.nob.rd1", n_rd1, 32'h0);
        check("rst.byp.prs", {31'b0, b_prs}, 32'h0);
        check("rst.byp.prt", {31'b0, b_prt}, 32'h0);
        repeat (2) clk_step();
        check_model("rst_hold");

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 1'b0, 5'd0, 1'b0);
        #1;
        check_model("rel0");
        clk_step();
        check("rel1.byp.rd1", b_rd1, 32'h0);
        check("rel1.byp.rd2", b_rd2, 32'h0);

        // Table-driven directed vectors.
        for (int k = 0; k < 16; k++) begin
            drive(vecs[k].we, vecs[k].wr, vecs[k].res, vecs[k].rs, vecs[k].rt,
                  vecs[k].iv, vecs[k].ir, vecs[k].fl);
            #1;
            check($sformatf("vec%0d.rd1", k), b_rd1, vecs[k].e_rd1);
            check($sformatf("vec%0d.rd2", k), b_rd2, vecs[k].e_rd2);
            check($sformatf("vec%0d.prs", k), {31'b0, b_prs}, {31'b0, vecs[k].e_prs});
            check($sformatf("vec%0d.prt", k), {31'b0, b_prt}, {31'b0, vecs[k].e_prt});
            check_model($sformatf("vec%0d", k));
            clk_step();
        end

        // BYPASS=0 instance: a same-cycle write shows the old value, and the new value one cycle later.
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        check("byp0.same.nob.rd1", n_rd1, 32'h0);
        check("byp0.same.nob.rd2", n_rd2, 32'h0);
        check("byp0.same.byp.rd1", b_rd1, 32'hA5A5A5A5);
        clk_step();
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        check("byp0.next.nob.rd1", n_rd1, 32'hA5A5A5A5);
        check("byp0.next.nob.rd2", n_rd2, 32'hA5A5A5A5);

        // Without bypass, a write-back does not hide the pending bit in its own cycle.
        clk_step();
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0);
        clk_step();
        drive(1'b1, 5'd8, 32'h88, 5'd8, 5'd8, 1'b0, 5'd0, 1'b0);
        #1;
        check("wb8.nob.prs", {31'b0, n_prs}, 32'h1);
        check("wb8.byp.prs", {31'b0, b_prs}, 32'h0);
        check_model("wb8");
        clk_step();

        // Asynchronous reset between edges.
        drive(1'b1, 5'd2, 32'h55, 5'd2, 5'd10, 1'b1, 5'd10, 1'b0);
        clk_step();
        drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd10, 1'b0, 5'd0, 1'b0);
        #1;
        check("arst.pre.rd1", b_rd1, 32'h55);
        check("arst.pre.prt", {31'b0, b_prt}, 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst.byp.rd1", b_rd1, 32'h0);
        check("arst.nob.rd1", n_rd1, 32'h0);
        check("arst.byp.prt", {31'b0, b_prt}, 32'h0);
        check("arst.nob.prt", {31'b0, n_prt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_model("arst.rel");
        clk_step();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), rand_idx(), $urandom, rand_idx(), rand_idx(),
                  ($urandom_range(0, 2) == 0), rand_idx(), ($urandom_range(0, 15) == 0));
            #1;
            check_model($sformatf("rnd%0d", c));
            clk_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
